gate_bist: RTL
==============

# gate_bist

Built-in self-test controller for the two-input basic-gate block: the hardware counterpart of its stimulus/monitor bench. It sweeps the full 2-bit truth table onto the gate block's A/B inputs, waits a settle interval, samples the six gate outputs Y0..Y5 and compares them against golden values. It reports pass/fail, the first failing vector, its mismatch mask and the failing-vector count. It sits between the top-level test/control logic and one gate-block instance.

## Interface
- SETTLE_CYCLES, 2: cycles each vector is held before sampling; legal range ≥1.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a sweep when sampled high in IDLE; ignored otherwise.
- y_in  in  6  gate-block outputs; bit i = Yi (Y0 AND, Y1 OR, Y2 NAND, Y3 NOR, Y4 XOR, Y5 XNOR).
- a_out  out  1  drives gate-block A.
- b_out  out  1  drives gate-block B.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  valid from done onward; 1 = all four vectors matched.
- fail_vec  out  2  index {A,B} of the first mismatching vector.
- fail_mask  out  6  y_in XOR golden for that first failing vector.
- mism_cnt  out  3  number of mismatching vectors, 0..4.

## Operation
- Reset (synchronous; dominates start): all outputs 0, state IDLE, settle counter 0, vector index 0.
- States:
  - IDLE: start=1 → RUN, with vector index 0 and settle counter 0.
  - RUN: {a_out,b_out} = vector index, applied in the order 00, 01, 10, 11. The counter increments each cycle. In the cycle where counter = SETTLE_CYCLES−1:
    - sample y_in and compare with GOLDEN[index];
    - reset the counter;
    - if index = 3, go to DONE; otherwise increment index.
  - DONE: for one cycle, done=1, busy=0 and pass = (mism_cnt==0); then go to IDLE. A start in DONE is ignored.
- Golden values, y_in[5:0] per vector:
  - 00 → 6'b101100
  - 01 → 6'b010110
  - 10 → 6'b010110
  - 11 → 6'b100011
- On a mismatch, mism_cnt increments (saturation is never needed; max is 4).
- Only the first mismatch of a sweep loads fail_vec and fail_mask; later mismatches leave them unchanged.
- Clear-on-start: in the cycle start is accepted, pass, fail_vec, fail_mask and mism_cnt clear to 0. Otherwise they hold from done until the next accepted start.
- a_out/b_out return to 0 in DONE and IDLE.
- busy=1 exactly while in RUN.

## Timing
- Start accepted at edge 0.
- Vector k is driven during cycles k·S+1 .. (k+1)·S, where S = SETTLE_CYCLES. y_in is sampled at the edge ending cycle (k+1)·S.
- busy is high for 4·S cycles. done is high in cycle 4·S+1; with default S=2, that is cycle 9 after the start edge.
- pass, mism_cnt, fail_vec and fail_mask are valid in the done cycle and hold afterwards.
- y_in is treated as combinational from a_out/b_out. It must settle within S cycles and is never sampled in the first cycle of a vector when S>1.
- Reset asserted mid-sweep: all outputs take reset values at the next edge, with no done pulse. A later start runs a full sweep from vector 00.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE. That gives a period of 4·S+2 cycles.

## Structure
- Package gate_bist_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the GOLDEN constant array [0:3] of 6-bit values;
  - the vector-count constant NUM_VEC=4.
- Sub-module gate_golden: combinational, 2-bit vector in → 6-bit expected value out. Used by gate_bist and reusable by benches.
- The settle counter is $clog2(SETTLE_CYCLES+1) bits wide.

## Test plan
- Correct gate block attached, S=2, pulse start:
  - a_out/b_out step 00,01,10,11 at two cycles each;
  - done in cycle 9;
  - pass=1, mism_cnt=0, fail_vec=0, fail_mask=0.
- Y4 forced to 0:
  - vectors 01 and 10 mismatch;
  - pass=0, mism_cnt=2, fail_vec=2'b01, fail_mask=6'b010000.
- All y_in forced to 6'b000000:
  - mism_cnt=4, fail_vec=2'b00, fail_mask=6'b101100.
- rst asserted in cycle 5 of a sweep:
  - next edge busy=0, a_out=b_out=0, no done;
  - a new start gives a full 9-cycle sweep with correct results.
- Start pulsed during RUN and during DONE:
  - no effect, single done pulse.
- Start held high:
  - done pulses every 10 cycles;
  - results clear at each accepted start.
- S=1:
  - done in cycle 5 after the start edge;
  - passing sweep gives pass=1.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared state encoding and golden truth table for the gate-block self-test
package gate_bist_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NUM_VEC = 4;
    localparam logic [5:0] GOLDEN [0:NUM_VEC-1] = '{6'b101100, 6'b010110, 6'b010110, 6'b100011};
endpackage

// File: rtl/gate_golden.sv
// gate_golden: expected Y5..Y0 of the basic-gate block for a given {A,B} vector
module gate_golden
    import gate_bist_pkg::*;
(
    input  logic [1:0] vec,
    output logic [5:0] golden
);
    assign golden = GOLDEN[vec];
endmodule

// File: rtl/gate_bist.sv
// gate_bist: sweeps the 2-bit truth table onto the gate block and checks its six outputs
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] fail_vec,
    output logic [5:0] fail_mask,
    output logic [2:0] mism_cnt
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [1:0] idx;
    logic [5:0] golden, mm;
    logic sample, accept, last;
    gate_golden u_golden (.vec(idx), .golden(golden));
    assign accept = state == IDLE && start;
    assign sample = state == RUN && cnt == CW'(SETTLE_CYCLES - 1);
    assign last = idx == 2'(NUM_VEC - 1);
    assign mm = y_in ^ golden;
    assign busy = state == RUN;
    assign done = state == DONE;
    assign a_out = busy & idx[1];
    assign b_out = busy & idx[0];
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        state_n = accept ? RUN : (sample && last) ? DONE : (state == DONE) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            pass <= 1'b0;
            fail_vec <= '0;
            fail_mask <= '0;
            mism_cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
            idx <= '0;
            pass <= 1'b0;
            fail_vec <= '0;
            fail_mask <= '0;
            mism_cnt <= '0;
        end else if (busy) begin
            cnt <= sample ? '0 : cnt + 1'b1;
            if (sample) begin
                idx <= idx + 1'b1;
                if (mm != '0) begin
                    mism_cnt <= mism_cnt + 1'b1;
                    if (mism_cnt == '0) begin
                        fail_vec <= idx;
                        fail_mask <= mm;
                    end
                end
                // pass is settled on the edge entering DONE so it is valid with the done pulse
                if (last)
                    pass <= mism_cnt == '0 && mm == '0;
            end
        end
    end
endmodule
